home_actuator_sequencer: RTL and testbench



---
 rtl/home_actuator_sequencer.sv | 159 +++++++++++++++
 tb/tb_home_actuator_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/home_actuator_sequencer.sv
// rtl/home_actuator_sequencer.sv - light hold, anti-short-cycle fan and alarm sequencer (optional macro SYNC_INPUTS_EN)
module home_actuator_sequencer #(
    parameter int TICK_DIV    = 1000,
    parameter int LIGHT_HOLD  = 30,
    parameter int FAN_MIN_ON  = 60,
    parameter int FAN_MIN_OFF = 30,
    parameter int ENTRY_DELAY = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pir,
    input  logic       isDark,
    input  logic       tempHigh,
    input  logic       authorized,
    input  logic       arm,
    output logic       lightOn,
    output logic       fanOn,
    output logic       alarmOn,
    output logic [1:0] armState
);

    // Counter width able to hold v, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

    localparam int PW = cnt_width(TICK_DIV - 1);
    localparam int LW = cnt_width(LIGHT_HOLD);
    localparam int FW = cnt_width((FAN_MIN_ON > FAN_MIN_OFF) ? FAN_MIN_ON : FAN_MIN_OFF);
    localparam int AW = cnt_width(ENTRY_DELAY);

    typedef enum logic {FAN_OFF = 1'b0, FAN_ON = 1'b1} fan_state_t;
    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        ENTRY    = 2'b10,
        ALARM    = 2'b11
    } arm_state_t;

    logic pir_i, dark_i, temp_i, auth_i, arm_i;

`ifdef SYNC_INPUTS_EN
    logic [4:0] sync_1, sync_2;

    // Two-flop synchronizers for every sensor and request input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {pir, isDark, tempHigh, authorized, arm};
            sync_2 <= sync_1;
        end
    end

    assign {pir_i, dark_i, temp_i, auth_i, arm_i} = sync_2;
`else
    assign {pir_i, dark_i, temp_i, auth_i, arm_i} = {pir, isDark, tempHigh, authorized, arm};
`endif

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    // Free-running prescaler; timer loads never restart it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    logic [LW-1:0] light_cnt;

    // Retriggerable light hold: a qualifying motion reloads, ticks drain it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_cnt <= '0;
            lightOn   <= 1'b0;
        end else if (pir_i && dark_i) begin
            light_cnt <= LW'(LIGHT_HOLD);
            lightOn   <= 1'b1;
        end else if (tick && light_cnt != '0) begin
            light_cnt <= light_cnt - LW'(1);
            lightOn   <= (light_cnt != LW'(1));
        end
    end

    fan_state_t    fan_state;
    logic [FW-1:0] fan_cnt;

    // Fan FSM: a state change is only allowed once its minimum dwell has drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fan_state <= FAN_OFF;
            fan_cnt   <= '0;
            fanOn     <= 1'b0;
        end else if (fan_state == FAN_OFF && temp_i && fan_cnt == '0) begin
            fan_state <= FAN_ON;
            fan_cnt   <= FW'(FAN_MIN_ON);
            fanOn     <= 1'b1;
        end else if (fan_state == FAN_ON && !temp_i && fan_cnt == '0) begin
            fan_state <= FAN_OFF;
            fan_cnt   <= FW'(FAN_MIN_OFF);
            fanOn     <= 1'b0;
        end else if (tick && fan_cnt != '0) begin
            fan_cnt <= fan_cnt - FW'(1);
        end
    end

    arm_state_t    arm_q;
    logic [AW-1:0] alarm_cnt;

    // Alarm FSM: authorization always disarms once armed; entry delay checks zero before draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q     <= DISARMED;
            alarm_cnt <= '0;
            alarmOn   <= 1'b0;
        end else begin
            case (arm_q)
                DISARMED: begin
                    if (arm_i) arm_q <= ARMED;
                end
                ARMED: begin
                    if (auth_i) begin
                        arm_q <= DISARMED;
                    end else if (pir_i) begin
                        arm_q     <= ENTRY;
                        alarm_cnt <= AW'(ENTRY_DELAY);
                    end
                end
                ENTRY: begin
                    if (auth_i) begin
                        arm_q <= DISARMED;
                    end else if (alarm_cnt == '0) begin
                        arm_q   <= ALARM;
                        alarmOn <= 1'b1;
                    end else if (tick) begin
                        alarm_cnt <= alarm_cnt - AW'(1);
                    end
                end
                ALARM: begin
                    if (auth_i) begin
                        arm_q   <= DISARMED;
                        alarmOn <= 1'b0;
                    end
                end
                default: begin
                    arm_q   <= DISARMED;
                    alarmOn <= 1'b0;
                end
            endcase
        end
    end

    assign armState = arm_q;

endmodule

// File: tb/tb_home_actuator_sequencer.sv
// tb/tb_home_actuator_sequencer.sv - self-checking bench for home_actuator_sequencer
module tb_home_actuator_sequencer;

`ifdef SYNC_INPUTS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pir = 1'b0, isDark = 1'b0, tempHigh = 1'b0, authorized = 1'b0, arm = 1'b0;
    logic [1:0] light_o, fan_o, alarm_o;
    logic [1:0] st0, st1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    home_actuator_sequencer #(.TICK_DIV(1), .LIGHT_HOLD(4), .FAN_MIN_ON(5),
                              .FAN_MIN_OFF(3), .ENTRY_DELAY(3)) u0 (
        .clk(clk), .rst_n(rst_n), .pir(pir), .isDark(isDark), .tempHigh(tempHigh),
        .authorized(authorized), .arm(arm), .lightOn(light_o[0]), .fanOn(fan_o[0]),
        .alarmOn(alarm_o[0]), .armState(st0));

    home_actuator_sequencer #(.TICK_DIV(3), .LIGHT_HOLD(2), .FAN_MIN_ON(2),
                              .FAN_MIN_OFF(1), .ENTRY_DELAY(0)) u1 (
        .clk(clk), .rst_n(rst_n), .pir(pir), .isDark(isDark), .tempHigh(tempHigh),
        .authorized(authorized), .arm(arm), .lightOn(light_o[1]), .fanOn(fan_o[1]),
        .alarmOn(alarm_o[1]), .armState(st1));

    // Model parameters per instance.
    int p_d [2] = '{1, 3};
    int p_l [2] = '{4, 2};
    int p_n [2] = '{5, 2};
    int p_f [2] = '{3, 1};
    int p_e [2] = '{3, 0};

    // Model state: time-stamped events measured in elapsed ticks.
    int n;
    int light_t [2];
    int fan_on [2];
    int fan_te [2];
    int ast [2];
    int a_te [2];
    logic [4:0] s1, s2, m_in;

    // Ticks occurring at edges 0..k when the prescaler wraps every d edges.
    function automatic int ticks_upto(input int k, input int d);
        return (k + 1) / d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            s1 = '0;
            s2 = '0;
            for (int i = 0; i < 2; i++) begin
                light_t[i] = -1;
                fan_on[i] = 0;
                fan_te[i] = -1;
                ast[i] = 0;
                a_te[i] = -1;
            end
        end else begin
`ifdef SYNC_INPUTS_EN
            m_in = s2;
            s2 = s1;
            s1 = {pir, isDark, tempHigh, authorized, arm};
`else
            m_in = {pir, isDark, tempHigh, authorized, arm};
`endif
            for (int i = 0; i < 2; i++) begin
                int el;
                if (m_in[4] && m_in[3]) light_t[i] = n;
                el = (fan_te[i] < 0) ? 1 << 30 :
                     ticks_upto(n - 1, p_d[i]) - ticks_upto(fan_te[i], p_d[i]);
                if (fan_on[i] == 0 && m_in[2] && el >= p_f[i]) begin
                    fan_on[i] = 1;
                    fan_te[i] = n;
                end else if (fan_on[i] == 1 && !m_in[2] && el >= p_n[i]) begin
                    fan_on[i] = 0;
                    fan_te[i] = n;
                end
                case (ast[i])
                    0: if (m_in[0]) ast[i] = 1;
                    1: begin
                        if (m_in[1]) ast[i] = 0;
                        else if (m_in[4]) begin
                            ast[i] = 2;
                            a_te[i] = n;
                        end
                    end
                    2: begin
                        if (m_in[1]) ast[i] = 0;
                        else if (ticks_upto(n - 1, p_d[i]) - ticks_upto(a_te[i], p_d[i]) >= p_e[i])
                            ast[i] = 3;
                    end
                    default: if (m_in[1]) ast[i] = 0;
                endcase
            end
            n = n + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 2; i++) begin
            int exp_l;
            exp_l = (light_t[i] >= 0 &&
                     ticks_upto(n - 1, p_d[i]) - ticks_upto(light_t[i], p_d[i]) < p_l[i]) ? 1 : 0;
            chk($sformatf("model_light%0d", i), int'(light_o[i]), exp_l);
            chk($sformatf("model_fan%0d", i), int'(fan_o[i]), fan_on[i]);
            chk($sformatf("model_alarm%0d", i), int'(alarm_o[i]), (ast[i] == 3) ? 1 : 0);
            chk($sformatf("model_state%0d", i), int'((i == 0) ? st0 : st1), ast[i]);
        end
    endtask

    // One clock: inputs already set; sample after the edge on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    int rec [16];
    int rec2 [16];

    initial begin
        repeat (3) cyc();
        chk("rst_light", int'(light_o), 0);
        chk("rst_fan", int'(fan_o), 0);
        chk("rst_alarm", int'(alarm_o), 0);
        chk("rst_state0", int'(st0), 0);
        chk("rst_state1", int'(st1), 0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single light pulse.
        pir = 1; isDark = 1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            rec[k] = int'(light_o[0]);
            pir = 0;
        end
        isDark = 0;
        for (int k = 0; k < 7; k++)
            chk($sformatf("light_pulse_k%0d", k), rec[k], (k >= LAT && k <= LAT + 3) ? 1 : 0);

        // Motion without darkness.
        for (int k = 0; k < 6; k++) begin
            pir = (k < 3);
            cyc();
            chk($sformatf("light_nodark_k%0d", k), int'(light_o[0]), 0);
        end
        pir = 0;
        repeat (3) cyc();

        // Retrigger extends the hold.
        isDark = 1;
        for (int k = 0; k < 10; k++) begin
            pir = (k == 0 || k == 2);
            cyc();
            rec[k] = int'(light_o[0]);
        end
        pir = 0;
        chk("light_retrig_hold", rec[LAT + 5], 1);
        chk("light_retrig_end", rec[LAT + 6], 0);

        // Reset asserted mid-hold drops the light at once.
        pir = 1;
        cyc();
        pir = 0;
        repeat (2) cyc();
        chk("light_before_rst", int'(light_o[0]), 1);
        rst_n = 0;
        #1;
        chk("light_async_rst", int'(light_o[0]), 0);
        isDark = 0;
        cyc();
        rst_n = 1;

        // Fan minimum on/off dwell.
        for (int k = 0; k < 15; k++) begin
            tempHigh = (k == 0 || k >= 7);
            cyc();
            rec[k] = int'(fan_o[0]);
        end
        tempHigh = 0;
        chk("fan_on_first", rec[LAT], 1);
        chk("fan_min_on_hold", rec[LAT + 5], 1);
        chk("fan_off", rec[LAT + 6], 0);
        chk("fan_min_off_hold", rec[LAT + 9], 0);
        chk("fan_reon", rec[LAT + 10], 1);

        // Arm, entry delay, alarm, disarm.
        arm = 1;
        repeat (2) cyc();
        arm = 0;
        repeat (LAT) cyc();
        chk("arm_armed", int'(st0), 1);
        for (int k = 0; k < 8; k++) begin
            pir = (k == 0);
            cyc();
            rec[k] = int'(st0);
            rec2[k] = int'(alarm_o[0]);
        end
        chk("entry_start", rec[LAT], 2);
        chk("entry_last", rec[LAT + 3], 2);
        chk("alarm_pre", rec2[LAT + 3], 0);
        chk("alarm_state", rec[LAT + 4], 3);
        chk("alarm_on", rec2[LAT + 4], 1);
        authorized = 1;
        cyc();
        authorized = 0;
        repeat (LAT) cyc();
        chk("disarm_state", int'(st0), 0);
        chk("disarm_alarm", int'(alarm_o[0]), 0);

        // Priority: authorized beats pir in ARMED.
        arm = 1;
        repeat (2) cyc();
        arm = 0;
        repeat (LAT) cyc();
        pir = 1; authorized = 1;
        cyc();
        pir = 0; authorized = 0;
        repeat (LAT) cyc();
        chk("prio_armed_auth", int'(st0), 0);

        // Priority: arm beats authorized in DISARMED.
        arm = 1; authorized = 1;
        cyc();
        arm = 0; authorized = 0;
        repeat (LAT) cyc();
        chk("prio_disarmed_arm", int'(st0), 1);

        // Authorization on the last entry cycle prevents the alarm.
        for (int k = 0; k < 7; k++) begin
            pir = (k == 0);
            authorized = (k == 4);
            cyc();
            chk($sformatf("entry_auth_noalarm_k%0d", k), int'(alarm_o[0]), 0);
        end
        pir = 0; authorized = 0;
        chk("entry_auth_state", int'(st0), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                #1;
                chk("rand_async_rst", int'({light_o, fan_o, alarm_o}), 0);
                cyc();
                rst_n = 1;
            end
            pir = ($urandom_range(0, 3) == 0);
            isDark = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) tempHigh = ~tempHigh;
            authorized = ($urandom_range(0, 19) == 0);
            arm = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
